note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/sound_pkg.sv | 39 +++
 rtl/note_ram.sv | 24 ++
 rtl/note_sequencer.sv | 152 +++++++++++++++
 tb/tb_note_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared encodings for the tone sequencer: FSM states, pitch codes and the
// pitch-to-divider table that drives the sine clock generator.
package sound_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [3:0] PITCH_A     = 4'd0;
    localparam logic [3:0] PITCH_DHIGH = 4'd1;
    localparam logic [3:0] PITCH_C     = 4'd2;
    localparam logic [3:0] PITCH_B     = 4'd3;
    localparam logic [3:0] PITCH_G     = 4'd4;
    localparam logic [3:0] PITCH_FIS   = 4'd5;
    localparam logic [3:0] PITCH_E     = 4'd6;
    localparam logic [3:0] PITCH_D     = 4'd7;
    localparam logic [3:0] PITCH_REST  = 4'd8;

    // Codes 8..15 are all rests and produce a zero divider.
    function automatic logic [4:0] pitch_maxval(input logic [3:0] code);
        logic [4:0] m;
        case (code)
            PITCH_A:     m = 5'd18;
            PITCH_DHIGH: m = 5'd13;
            PITCH_C:     m = 5'd15;
            PITCH_B:     m = 5'd16;
            PITCH_G:     m = 5'd20;
            PITCH_FIS:   m = 5'd21;
            PITCH_E:     m = 5'd24;
            PITCH_D:     m = 5'd27;
            default:     m = 5'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/note_ram.sv
// Note memory: one write port, registered read. Contents are not touched by
// reset so a song survives an abort.
module note_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int W     = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays a stored list of {pitch, duration} notes, counting sample ticks per
// note with an optional silent gap between notes. All outputs are registered.
module note_sequencer
    import sound_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int DUR_W     = 13,
    parameter int GAP_TICKS = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [3:0]       wr_pitch,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [5:0]       len,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [4:0]       sine_maxval,
    output logic             tone_on,
    output logic             tone_restart,
    output logic [4:0]       note_idx,
    output logic             done
);

    localparam int GAP_W = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit LEGATO = (GAP_TICKS == 0);

    state_t             state, state_nxt;
    logic [5:0]         len_r;
    logic               loop_r;
    logic [3:0]         pitch_r;
    logic [DUR_W-1:0]   dur_r;
    logic [DUR_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DUR_W+3:0]   rd_data;
    logic [3:0]         rd_pitch, play_pitch;
    logic               start_ok, play_last, gap_last, note_end, has_next, wrap;
    logic               busy_d, tone_d, restart_d, done_d;
    logic [4:0]         max_d, idx_d;

    // Read address follows the next index so the word is ready during FETCH.
    note_ram #(.DEPTH(DEPTH), .AW(5), .W(4 + DUR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en && (state == S_IDLE)),
        .waddr (wr_addr),
        .wdata ({wr_pitch, wr_dur}),
        .raddr (idx_d),
        .rdata (rd_data)
    );

    assign rd_pitch  = rd_data[DUR_W +: 4];
    assign start_ok  = start && (len != 6'd0) && (len <= 6'd32);
    // cnt holds ticks already seen; a zero duration still plays one tick.
    assign play_last = tick && (((DUR_W+1)'(cnt) + (DUR_W+1)'(1)) >= (DUR_W+1)'(dur_r));
    assign gap_last  = tick && (gap_cnt == GAP_LAST);
    assign note_end  = ((state == S_PLAY) && play_last && LEGATO) ||
                       ((state == S_GAP) && gap_last);
    assign has_next  = (6'(note_idx) + 6'd1) < len_r;
    assign wrap      = has_next || loop_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            sine_maxval  <= 5'd0;
            tone_on      <= 1'b0;
            tone_restart <= 1'b0;
            note_idx     <= 5'd0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= busy_d;
            sine_maxval  <= max_d;
            tone_on      <= tone_d;
            tone_restart <= restart_d;
            note_idx     <= idx_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_ok) state_nxt = S_FETCH;
                S_FETCH: state_nxt = S_PLAY;
                S_PLAY:  if (play_last)
                             state_nxt = LEGATO ? (wrap ? S_FETCH : S_IDLE) : S_GAP;
                S_GAP:   if (gap_last) state_nxt = wrap ? S_FETCH : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        play_pitch = (state == S_FETCH) ? rd_pitch : pitch_r;
        busy_d     = (state_nxt != S_IDLE);
        idx_d      = note_idx;
        done_d     = 1'b0;
        restart_d  = 1'b0;
        tone_d     = 1'b0;
        max_d      = 5'd0;
        if (!stop) begin
            if ((state == S_IDLE) && start_ok)
                idx_d = 5'd0;
            if (note_end) begin
                if (has_next)    idx_d  = note_idx + 5'd1;
                else if (loop_r) idx_d  = 5'd0;
                else             done_d = 1'b1;
            end
        end
        if (state_nxt == S_PLAY) begin
            restart_d = (state == S_FETCH);
            tone_d    = (play_pitch < PITCH_REST);
            max_d     = pitch_maxval(play_pitch);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_r   <= 6'd0;
            loop_r  <= 1'b0;
            pitch_r <= 4'd0;
            dur_r   <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            if ((state == S_IDLE) && start_ok) begin
                len_r  <= len;
                loop_r <= loop_en;
            end
            if (state == S_FETCH) begin
                pitch_r <= rd_pitch;
                dur_r   <= rd_data[DUR_W-1:0];
                cnt     <= '0;
                gap_cnt <= '0;
            end
            if ((state == S_PLAY) && tick)
                cnt <= cnt + DUR_W'(1);
            if ((state == S_GAP) && tick)
                gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Runs a legato (GAP_TICKS=0) and a gapped (GAP_TICKS=2) sequencer side by side
// against a note-by-note playback script, plus a vector table and directed runs.
module tb_note_sequencer;

    localparam int DUR_W = 13;
    localparam int MAXC  = 512;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0, wr_en = 1'b0, loop_en = 1'b0, start = 1'b0, stop = 1'b0;
    logic [4:0]       wr_addr = '0;
    logic [3:0]       wr_pitch = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic [5:0]       len = '0;

    logic       busy0, tone0, rst0, done0, busy2, tone2, rst2, done2;
    logic [4:0] max0, idx0, max2, idx2;

    always #5 clk = ~clk;

    note_sequencer #(.DEPTH(32), .DUR_W(DUR_W), .GAP_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pitch(wr_pitch), .wr_dur(wr_dur), .len(len), .loop_en(loop_en),
        .start(start), .stop(stop), .busy(busy0), .sine_maxval(max0),
        .tone_on(tone0), .tone_restart(rst0), .note_idx(idx0), .done(done0));

    note_sequencer #(.DEPTH(32), .DUR_W(DUR_W), .GAP_TICKS(2)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pitch(wr_pitch), .wr_dur(wr_dur), .len(len), .loop_en(loop_en),
        .start(start), .stop(stop), .busy(busy2), .sine_maxval(max2),
        .tone_on(tone2), .tone_restart(rst2), .note_idx(idx2), .done(done2));

    typedef struct packed {
        logic       busy, tone, restart, done;
        logic [4:0] maxv, idx;
    } outs_t;

    typedef struct {
        int         ln;
        logic [3:0] pitch;
        bit         with_stop;
        bit         e_busy;
        int         e_max;
        bit         e_tone;
    } vec_t;

    outs_t      exp_t [2][MAXC];
    bit         care  [2][MAXC];
    bit         tk    [MAXC];
    logic [3:0] mp    [32];
    int         md    [32];
    int         checks = 0, errors = 0;
    int         d0_done, d2_done, d0_restarts, d2_tones;
    vec_t       tbl [21];

    function automatic logic [4:0] ref_max(input logic [3:0] p);
        case (p)
            4'd0: return 5'd18;  4'd1: return 5'd13;  4'd2: return 5'd15;  4'd3: return 5'd16;
            4'd4: return 5'd20;  4'd5: return 5'd21;  4'd6: return 5'd24;  4'd7: return 5'd27;
            default: return 5'd0;
        endcase
    endfunction

    function automatic outs_t act(input int k);
        if (k == 0) return outs_t'({busy0, tone0, rst0, done0, max0, idx0});
        return outs_t'({busy2, tone2, rst2, done2, max2, idx2});
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_cyc(input string name, input int k, input int c);
        outs_t a, e;
        a = act(k);
        e = exp_t[k][c];
        if (!care[k][c]) begin
            a.idx = '0;
            e.idx = '0;
        end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s gap%0d cyc %0d got busy=%0b tone=%0b rst=%0b done=%0b max=%0d idx=%0d want busy=%0b tone=%0b rst=%0b done=%0b max=%0d idx=%0d",
                     name, k * 2, c, a.busy, a.tone, a.restart, a.done, a.maxv, a.idx,
                     e.busy, e.tone, e.restart, e.done, e.maxv, e.idx);
        end
    endtask

    // Playback script: each note is one fetch cycle, max(dur,1) counted ticks of
    // sound, then `gap` counted ticks of silence; then advance, wrap or finish.
    task automatic build(input int k, input int gap, input int ln, input bit lp, input int n);
        int c, idx, cnt, need;
        bit first, fin;
        c = 1; idx = 0; fin = 0;
        for (int i = 0; i < n; i++) begin
            exp_t[k][i] = '0;
            care[k][i]  = 0;
        end
        while (c < n && !fin) begin
            exp_t[k][c] = '{busy: 1'b1, tone: 1'b0, restart: 1'b0, done: 1'b0, maxv: 5'd0, idx: 5'(idx)};
            care[k][c] = 1; c++;
            need = (md[idx] == 0) ? 1 : md[idx];
            cnt = 0; first = 1;
            while (cnt < need && c < n) begin
                exp_t[k][c] = '{busy: 1'b1, tone: (mp[idx] < 4'd8), restart: first, done: 1'b0,
                                maxv: ref_max(mp[idx]), idx: 5'(idx)};
                care[k][c] = 1; first = 0;
                if (tk[c]) cnt++;
                c++;
            end
            cnt = 0;
            while (cnt < gap && c < n) begin
                exp_t[k][c] = '{busy: 1'b1, tone: 1'b0, restart: 1'b0, done: 1'b0, maxv: 5'd0, idx: 5'(idx)};
                care[k][c] = 1;
                if (tk[c]) cnt++;
                c++;
            end
            if (c < n) begin
                if (idx < ln - 1) idx++;
                else if (lp) idx = 0;
                else begin
                    for (int i = c; i < n; i++) begin
                        exp_t[k][i] = '{busy: 1'b0, tone: 1'b0, restart: 1'b0, done: (i == c), maxv: 5'd0, idx: 5'(idx)};
                        care[k][i] = 1;
                    end
                    fin = 1;
                end
            end
        end
    endtask

    task automatic wr(input int a, input logic [3:0] p, input int d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 5'(a); wr_pitch = p; wr_dur = DUR_W'(d);
        mp[a] = p; md[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Cycle 0 carries start; kill_at applies stop (or reset when kill_rst).
    task automatic run(input string name, input int ln, input bit lp, input int n,
                       input int prob, input int kill_at, input bit kill_rst);
        for (int c = 0; c < n; c++) tk[c] = ($urandom_range(99) < prob);
        build(0, 0, ln, lp, n);
        build(1, 2, ln, lp, n);
        for (int k = 0; k < 2; k++)
            for (int i = kill_at + 1; i < n; i++) begin
                exp_t[k][i] = '0;
                care[k][i]  = kill_rst;
            end
        d0_done = -1; d2_done = -1; d0_restarts = 0; d2_tones = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start   = (c == 0);
            len     = 6'(ln);
            loop_en = lp;
            tick    = tk[c];
            stop    = (c == kill_at) && !kill_rst;
            reset   = !((c == kill_at) && kill_rst);
            wr_en   = (c >= 2) && exp_t[0][c].busy && exp_t[1][c].busy && ($urandom_range(3) == 0);
            wr_addr = 5'($urandom_range(31));
            wr_pitch = 4'($urandom_range(15));
            wr_dur  = DUR_W'($urandom_range(7));
            @(negedge clk);
            check_cyc(name, 0, c);
            check_cyc(name, 1, c);
            if (done0 && d0_done < 0) d0_done = c;
            if (done2 && d2_done < 0) d2_done = c;
            if (rst0) d0_restarts++;
            if (tone2) d2_tones++;
        end
        @(posedge clk); #1;
        start = 0; stop = 0; tick = 0; wr_en = 0; reset = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_state gap0", int'(act(0)), 0);
        check_val("reset_state gap2", int'(act(1)), 0);
        @(posedge clk); #1 reset = 1'b1;

        for (int a = 0; a < 32; a++) wr(a, 4'($urandom_range(15)), $urandom_range(3));

        tbl[0] = '{1, 4'd0, 0, 1, 18, 1};  tbl[1] = '{1, 4'd1, 0, 1, 13, 1};
        tbl[2] = '{1, 4'd2, 0, 1, 15, 1};  tbl[3] = '{1, 4'd3, 0, 1, 16, 1};
        tbl[4] = '{1, 4'd4, 0, 1, 20, 1};  tbl[5] = '{1, 4'd5, 0, 1, 21, 1};
        tbl[6] = '{1, 4'd6, 0, 1, 24, 1};  tbl[7] = '{1, 4'd7, 0, 1, 27, 1};
        for (int p = 8; p < 16; p++) tbl[p] = '{1, 4'(p), 0, 1, 0, 0};
        tbl[16] = '{0,  4'd4, 0, 0, 0, 0};
        tbl[17] = '{33, 4'd4, 0, 0, 0, 0};
        tbl[18] = '{63, 4'd4, 0, 0, 0, 0};
        tbl[19] = '{32, 4'd5, 0, 1, 21, 1};
        tbl[20] = '{1,  4'd4, 1, 0, 0, 0};
        for (int i = 0; i < 21; i++) begin
            wr(0, tbl[i].pitch, 1);
            @(posedge clk); #1;
            start = 1; len = 6'(tbl[i].ln); stop = tbl[i].with_stop;
            @(posedge clk); #1;
            start = 0; stop = 0;
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("tbl%0d busy", i), busy0, tbl[i].e_busy);
            check_val($sformatf("tbl%0d maxval", i), max0, tbl[i].e_max);
            check_val($sformatf("tbl%0d tone", i), tone0, tbl[i].e_tone);
            check_val($sformatf("tbl%0d maxval_gap", i), max2, tbl[i].e_max);
            @(posedge clk); #1 stop = 1;
            @(posedge clk); #1 stop = 0;
        end

        wr(0, 4'd4, 4); wr(1, 4'd0, 2); wr(2, 4'd1, 3);
        run("three_notes", 3, 0, 30, 100, 28, 0);
        check_val("three_notes done_cycle", d0_done, 13);
        check_val("three_notes restarts", d0_restarts, 3);
        check_val("three_notes gap2 done_cycle", d2_done, 19);

        wr(0, 4'd3, 1); wr(1, 4'd2, 1);
        run("gap_notes", 2, 0, 20, 100, 18, 0);
        check_val("gap_notes done_cycle", d2_done, 9);
        check_val("gap_notes tone_cycles", d2_tones, 2);

        wr(0, 4'd9, 5);
        run("rest", 1, 0, 20, 100, 18, 0);
        check_val("rest done_cycle", d0_done, 7);

        wr(0, 4'd6, 6); wr(1, 4'd7, 3);
        run("loop_stop", 2, 1, 40, 100, 25, 0);
        check_val("loop no_done", d0_done, -1);
        check_val("loop gap2 no_done", d2_done, -1);

        run("reset_mid", 3, 0, 40, 100, 5, 1);
        check_val("reset_mid no_done", d0_done, -1);
        run("replay", 3, 0, 60, 100, 58, 0);

        for (int a = 0; a < 32; a++) wr(a, 4'($urandom_range(15)), $urandom_range(3));
        for (int i = 0; i < 8; i++)
            run("random", $urandom_range(1, 6), 1'($urandom_range(1)), 250, $urandom_range(20, 70), 248, 0);
        run("len32", 32, 0, 400, 90, 398, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
